// File: rtl/led_pkg.sv
// Shared constants and types for the LED scan controller.
package led_pkg;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex nibble to active-low {g,f,e,d,c,b,a}; index = nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Slot phase: anodes dark at slot start, then the digit is shown.
  typedef enum logic {PH_BLANK, PH_SHOW} phase_e;

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Datapath-to-display bundle: digit data and strobes in, pin drives out.
interface led_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic                    lz_en;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output digits, dp_in, blank_in, load, lz_en,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  digits, dp_in, blank_in, load, lz_en,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/led_seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module led_seg_decode
  import led_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup from the shared segment constants.
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// N-digit multiplexed common-anode 7-segment driver with prescaler,
// inter-digit blanking, per-digit masks, leading-zero suppression and
// frame-synchronous double buffering.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned BLANK_CYC  = 16
) (
  input logic           clk_in,
  input logic           rst,
  led_scan_ctrl_if.slave bus
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic                    slot_end;
  logic                    frame_wrap;
  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_dark;
  logic [NUM_DIGITS-1:0]   an_show;
  logic [6:0]              dec_seg;
  phase_e                  phase;

  assign slot_end   = (pcnt == PCNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  // Prescaler and scan index.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= frame_wrap ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Pending buffer takes loads; active copies pending only at frame wrap.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
    end else begin
      if (frame_wrap) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
      end
      if (bus.load) begin
        pend_digits <= bus.digits;
        pend_dp     <= bus.dp_in;
        pend_blank  <= bus.blank_in;
      end
    end
  end

  // Leading-zero mask: walk from the most significant digit down while all zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      zero_run = zero_run && (act_digits[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      if (j != NUM_DIGITS - 1) lz_mask[NUM_DIGITS-1-j] = bus.lz_en && zero_run;
    end
  end

  // Select the data and anode pattern for the digit under scan.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    an_show  = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib    = act_digits[4*i +: 4];
        cur_dp     = act_dp[i];
        cur_dark   = act_blank[i] | lz_mask[i];
        an_show[i] = 1'b0;
      end
    end
  end

  // Slot phase from prescaler position.
  always_comb begin
    phase = (pcnt < BLANK_END) ? PH_BLANK : PH_SHOW;
  end

  led_seg_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Registered pin drives and frame pulse.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      bus.an         <= '1;
      bus.seg        <= SEG_BLANK;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= frame_wrap;
      if (phase == PH_BLANK) begin
        bus.an  <= '1;
        bus.seg <= SEG_BLANK;
        bus.dp  <= 1'b1;
      end else begin
        bus.an  <= an_show;
        bus.seg <= cur_dark ? SEG_BLANK : dec_seg;
        bus.dp  <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl (4 digits, CLK_DIV=8, BLANK_CYC=2).
module tb_led_scan_ctrl;

  localparam int ND    = 4;
  localparam int CD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * CD;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;

  always #5 clk_in = ~clk_in;

  led_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  led_scan_ctrl #(
    .NUM_DIGITS (ND),
    .CLK_DIV    (CD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edge count since reset plus the two buffers.
  int          k;
  logic [15:0] m_pend_d, m_act_d;
  logic [3:0]  m_pend_dp, m_act_dp, m_pend_b, m_act_b;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dpm;
    logic [3:0]  blk;
    logic        lz;
    int          dig;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t (edge %0d)", name, act, exp, $time, k);
    end
  endtask

  // Expected outputs after edge k come from the scan position before that edge.
  task automatic model_edge();
    int   p, d;
    logic dark;
    p = (k - 1) % CD;
    d = ((k - 1) / CD) % ND;
    if (p < BC) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      exp_an    = 4'hF;
      exp_an[d] = 1'b0;
      dark      = m_act_b[d] || (bus.lz_en && d != 0 && (m_act_d >> (4 * d)) == 16'h0);
      exp_seg   = dark ? 7'h7F : hex7(m_act_d[4*d +: 4]);
      exp_dp    = ~m_act_dp[d];
    end
    exp_fd = (k % FRAME == 0);
    if (k % FRAME == 0) begin
      m_act_d  = m_pend_d;
      m_act_dp = m_pend_dp;
      m_act_b  = m_pend_b;
    end
    if (bus.load) begin
      m_pend_d  = bus.digits;
      m_pend_dp = bus.dp_in;
      m_pend_b  = bus.blank_in;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    k++;
    model_edge();
    @(negedge clk_in);
    chk("an", {28'h0, bus.an}, {28'h0, exp_an});
    chk("seg", {25'h0, bus.seg}, {25'h0, exp_seg});
    chk("dp", {31'h0, bus.dp}, {31'h0, exp_dp});
    chk("frame_done", {31'h0, bus.frame_done}, {31'h0, exp_fd});
    chk("one_anode", ($countones(~bus.an) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  // Reset with a load attempt held during reset, which must be ignored.
  task automatic do_reset();
    rst          = 1'b0;
    bus.load     = 1'b1;
    bus.digits   = 16'hFFFF;
    bus.dp_in    = 4'hF;
    bus.blank_in = 4'h0;
    #1;
    chk("rst_an", {28'h0, bus.an}, 32'hF);
    chk("rst_seg", {25'h0, bus.seg}, 32'h7F);
    chk("rst_dp", {31'h0, bus.dp}, 32'h1);
    chk("rst_fd", {31'h0, bus.frame_done}, 32'h0);
    repeat (3) @(negedge clk_in);
    chk("rst_hold_an", {28'h0, bus.an}, 32'hF);
    bus.load   = 1'b0;
    bus.digits = 16'h0;
    bus.dp_in  = 4'h0;
    rst        = 1'b1;
    k          = 0;
    m_pend_d = '0; m_act_d = '0; m_pend_dp = '0; m_act_dp = '0; m_pend_b = '0; m_act_b = '0;
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] dpm, input logic [3:0] blk);
    bus.digits   = d;
    bus.dp_in    = dpm;
    bus.blank_in = blk;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  initial begin
    logic [3:0]  an_t;
    logic [15:0] msk;

    vt[0]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, 7'h19, 1'b1};
    vt[1]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 1, 7'h30, 1'b1};
    vt[2]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 2, 7'h24, 1'b1};
    vt[3]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 3, 7'h79, 1'b1};
    vt[4]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 3, 7'h7F, 1'b1};
    vt[5]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 2, 7'h7F, 1'b1};
    vt[6]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 1, 7'h12, 1'b1};
    vt[7]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 0, 7'h40, 1'b1};
    vt[8]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 0, 7'h40, 1'b1};
    vt[9]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 1, 7'h7F, 1'b1};
    vt[10] = '{16'h0000, 4'h0, 4'h0, 1'b1, 3, 7'h7F, 1'b1};
    vt[11] = '{16'h1234, 4'h4, 4'h1, 1'b0, 2, 7'h24, 1'b0};
    vt[12] = '{16'h1234, 4'h4, 4'h1, 1'b0, 0, 7'h7F, 1'b1};
    vt[13] = '{16'h1234, 4'h4, 4'h1, 1'b0, 1, 7'h30, 1'b1};
    vt[14] = '{16'h0A0B, 4'h0, 4'h0, 1'b0, 3, 7'h40, 1'b1};
    vt[15] = '{16'h0A0B, 4'h0, 4'h0, 1'b1, 3, 7'h7F, 1'b1};
    vt[16] = '{16'h0A0B, 4'h0, 4'h0, 1'b1, 1, 7'h40, 1'b1};
    vt[17] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 0, 7'h0E, 1'b1};
    vt[18] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 3, 7'h46, 1'b1};
    vt[19] = '{16'h0050, 4'h0, 4'h0, 1'b0, 3, 7'h40, 1'b1};

    bus.load = 1'b0; bus.lz_en = 1'b0; bus.digits = '0; bus.dp_in = '0; bus.blank_in = '0;
    k = 0;
    @(negedge clk_in);

    // Static display vectors, checked in the second frame after a single load.
    for (int t = 0; t < NV; t++) begin
      do_reset();
      bus.lz_en = vt[t].lz;
      load_word(vt[t].digits, vt[t].dpm, vt[t].blk);
      run_to(FRAME + CD * vt[t].dig + 5);
      an_t = 4'hF;
      an_t[vt[t].dig] = 1'b0;
      chk("vec_an", {28'h0, bus.an}, {28'h0, an_t});
      chk("vec_seg", {25'h0, bus.seg}, {25'h0, vt[t].seg});
      chk("vec_dp", {31'h0, bus.dp}, {31'h0, vt[t].dpo});
    end

    // First SHOW after reset lands on edge BLANK_CYC+1 for digit 0.
    do_reset();
    bus.lz_en = 1'b0;
    run_to(BC);
    chk("first_blank_an", {28'h0, bus.an}, 32'hF);
    run_to(BC + 1);
    chk("first_show_an", {28'h0, bus.an}, 32'hE);

    // Mid-frame load stays hidden until the wrap; load on the wrap edge waits a frame.
    do_reset();
    bus.lz_en = 1'b0;
    load_word(16'h1234, 4'h0, 4'h0);
    run_to(44);
    load_word(16'hAAAA, 4'h0, 4'h0);
    run_to(60);
    chk("tear_old", {25'h0, bus.seg}, 32'h79);
    run_to(69);
    chk("tear_new", {25'h0, bus.seg}, 32'h08);
    run_to(95);
    load_word(16'h5555, 4'h0, 4'h0);
    chk("wrap_fd", {31'h0, bus.frame_done}, 32'h1);
    run_to(101);
    chk("wrap_old", {25'h0, bus.seg}, 32'h08);
    run_to(133);
    chk("wrap_new", {25'h0, bus.seg}, 32'h12);

    // Reset during digit 2 SHOW clears outputs without a clock edge.
    do_reset();
    load_word(16'h1234, 4'h0, 4'h0);
    run_to(52);
    chk("pre_rst_an", {28'h0, bus.an}, 32'hB);
    rst = 1'b0;
    #1;
    chk("async_an", {28'h0, bus.an}, 32'hF);
    chk("async_seg", {25'h0, bus.seg}, 32'h7F);
    chk("async_dp", {31'h0, bus.dp}, 32'h1);
    chk("async_fd", {31'h0, bus.frame_done}, 32'h0);
    do_reset();
    run_to(BC + 1);
    chk("restart_an", {28'h0, bus.an}, 32'hE);
    chk("restart_seg", {25'h0, bus.seg}, 32'h40);
    run_to(FRAME + 5);
    chk("pend_lost_seg", {25'h0, bus.seg}, 32'h40);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      case ($urandom_range(0, 4))
        0: msk = 16'hFFFF;
        1: msk = 16'h00FF;
        2: msk = 16'h000F;
        3: msk = 16'h0F0F;
        default: msk = 16'h0000;
      endcase
      bus.digits   = 16'($urandom) & msk;
      bus.dp_in    = 4'($urandom);
      bus.blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      bus.load     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 63) == 0) bus.lz_en = ~bus.lz_en;
      tick();
      if (n == 1200) do_reset();
    end
    bus.load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
